param_block_interleaver: RTL

PARAM_BLOCK_INTERLEAVER -- requirements
Module: param_block_interleaver

---
 rtl/param_block_interleaver_pkg.sv | 15 +
 rtl/intlv_dpram.sv | 37 +++
 rtl/param_block_interleaver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/param_block_interleaver_pkg.sv
// Purpose: shared defaults and mode encoding for the ping-pong block interleaver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package param_block_interleaver_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_ROWS = 12;
  localparam int DEF_COLS = 16;

  typedef enum logic {
    MODE_INTLV   = 1'b0,
    MODE_DEINTLV = 1'b1
  } mode_e;

endpackage

// File: rtl/intlv_dpram.sv
// Purpose: one bank of interleaver storage, single write port, single registered read port.
// Latency: read data appears the cycle after re_i; write lands at the clock edge.
// Backpressure: none; rdata_o holds its value whenever re_i is low.
module intlv_dpram
  import param_block_interleaver_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_ROWS * DEF_COLS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array: plain write port, no reset on the contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register: only moves on re_i so a stalled output stays stable.
  always_ff @(posedge clk) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_block_interleaver.sv
// Purpose: ping-pong ROWSxCOLS block interleaver/deinterleaver (mode latched per block).
// Latency: first output 2 cycles after the last input of a block when the read side is idle.
// Backpressure: in_ready low only while the write bank is still full; out_ready stalls the read side.
module param_block_interleaver
  import param_block_interleaver_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_sob
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [AW-1:0] K_LAST   = AW'(N - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(ROWS - 1);
  localparam logic [AW-1:0] COL_STEP = AW'(COLS);

  // Global state
  logic          alive_q;
  logic [1:0]    full_q, full_d;
  mode_e         bank_mode_q [2];
  mode_e         bank_mode_d [2];
  // Write side: k counter plus row/col counters; wr_tr_q = (k mod ROWS)*COLS + k div ROWS
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_k_q, wr_k_d, wr_tr_q, wr_tr_d;
  logic [RW-1:0] wr_r_q, wr_r_d;
  logic [CW-1:0] wr_c_q, wr_c_d;
  // Read side: same counter set walking j
  logic          rd_active_q, rd_active_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_j_q, rd_j_d, rd_tr_q, rd_tr_d;
  logic [RW-1:0] rd_r_q, rd_r_d;
  logic [CW-1:0] rd_c_q, rd_c_d;
  // Output stage bookkeeping (data itself lives in the bank read registers)
  logic          out_valid_q, out_valid_d, out_sob_q, out_sob_d;
  logic          out_last_q, out_last_d, out_bank_q, out_bank_d;

  logic          in_fire, wr_last, release_now, adv, rd_go, rd_last;
  mode_e         wr_mode;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] rdata [2];

  // A bank whose last sample leaves this cycle can be refilled in the same cycle,
  // which keeps in_ready high across block boundaries at full rate.
  assign release_now = out_valid_q & out_ready & out_last_q;
  assign in_ready    = alive_q & (~full_q[wr_bank_q] | (release_now & (out_bank_q == wr_bank_q)));
  assign in_fire     = in_valid & in_ready;
  assign wr_last     = (wr_k_q == K_LAST);
  assign wr_mode     = (wr_k_q == '0) ? mode_e'(mode) : bank_mode_q[wr_bank_q];
  assign wr_addr     = (wr_mode == MODE_DEINTLV) ? wr_tr_q : wr_k_q;

  assign adv     = ~out_valid_q | out_ready;
  assign rd_go   = alive_q & adv & (rd_active_q | full_q[rd_bank_q]);
  assign rd_last = (rd_j_q == K_LAST);
  assign rd_addr = (bank_mode_q[rd_bank_q] == MODE_INTLV) ? rd_tr_q : rd_j_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    intlv_dpram #(.DW(DW), .DEPTH(N), .AW(AW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (in_fire && (wr_bank_q == 1'(b))),
      .waddr_i (wr_addr),
      .wdata_i (in_data),
      .re_i    (rd_go && (rd_bank_q == 1'(b))),
      .raddr_i (rd_addr),
      .rdata_o (rdata[b])
    );
  end

  assign out_data  = rdata[out_bank_q];
  assign out_valid = out_valid_q;
  assign out_sob   = out_sob_q;

  // Write side: advance counters on each accept, latch mode at k=0, flip bank after k=N-1
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_k_d      = wr_k_q;
    wr_r_d      = wr_r_q;
    wr_c_d      = wr_c_q;
    wr_tr_d     = wr_tr_q;
    bank_mode_d = bank_mode_q;
    if (in_fire) begin
      if (wr_k_q == '0) bank_mode_d[wr_bank_q] = mode_e'(mode);
      if (wr_last) begin
        wr_bank_d = ~wr_bank_q;
        wr_k_d    = '0;
        wr_r_d    = '0;
        wr_c_d    = '0;
        wr_tr_d   = '0;
      end else begin
        wr_k_d = wr_k_q + 1'b1;
        if (wr_r_q == R_LAST) begin
          wr_r_d  = '0;
          wr_c_d  = wr_c_q + 1'b1;
          wr_tr_d = AW'(wr_c_q) + 1'b1;
        end else begin
          wr_r_d  = wr_r_q + 1'b1;
          wr_tr_d = wr_tr_q + COL_STEP;
        end
      end
    end
  end

  // Bank occupancy: set when a block completes, cleared when its last sample is taken
  always_comb begin
    full_d = full_q;
    if (release_now) full_d[out_bank_q] = 1'b0;
    if (in_fire && wr_last) full_d[wr_bank_q] = 1'b1;
  end

  // Read side: issue one read per free output slot, walk j, hand over to the other bank at j=N-1
  always_comb begin
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    rd_j_d      = rd_j_q;
    rd_r_d      = rd_r_q;
    rd_c_d      = rd_c_q;
    rd_tr_d     = rd_tr_q;
    out_valid_d = out_valid_q;
    out_sob_d   = out_sob_q;
    out_last_d  = out_last_q;
    out_bank_d  = out_bank_q;
    if (adv) out_valid_d = rd_go;
    if (rd_go) begin
      out_sob_d  = (rd_j_q == '0);
      out_last_d = rd_last;
      out_bank_d = rd_bank_q;
      if (rd_last) begin
        rd_active_d = 1'b0;
        rd_bank_d   = ~rd_bank_q;
        rd_j_d      = '0;
        rd_r_d      = '0;
        rd_c_d      = '0;
        rd_tr_d     = '0;
      end else begin
        rd_active_d = 1'b1;
        rd_j_d      = rd_j_q + 1'b1;
        if (rd_r_q == R_LAST) begin
          rd_r_d  = '0;
          rd_c_d  = rd_c_q + 1'b1;
          rd_tr_d = AW'(rd_c_q) + 1'b1;
        end else begin
          rd_r_d  = rd_r_q + 1'b1;
          rd_tr_d = rd_tr_q + COL_STEP;
        end
      end
    end
  end

  // State registers; reset drops any partial or full bank
  always_ff @(posedge clk) begin
    if (!rst) begin
      alive_q     <= 1'b0;
      full_q      <= '0;
      bank_mode_q <= '{default: MODE_INTLV};
      wr_bank_q   <= 1'b0;
      wr_k_q      <= '0;
      wr_r_q      <= '0;
      wr_c_q      <= '0;
      wr_tr_q     <= '0;
      rd_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_j_q      <= '0;
      rd_r_q      <= '0;
      rd_c_q      <= '0;
      rd_tr_q     <= '0;
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_bank_q  <= 1'b0;
    end else begin
      alive_q     <= 1'b1;
      full_q      <= full_d;
      bank_mode_q <= bank_mode_d;
      wr_bank_q   <= wr_bank_d;
      wr_k_q      <= wr_k_d;
      wr_r_q      <= wr_r_d;
      wr_c_q      <= wr_c_d;
      wr_tr_q     <= wr_tr_d;
      rd_active_q <= rd_active_d;
      rd_bank_q   <= rd_bank_d;
      rd_j_q      <= rd_j_d;
      rd_r_q      <= rd_r_d;
      rd_c_q      <= rd_c_d;
      rd_tr_q     <= rd_tr_d;
      out_valid_q <= out_valid_d;
      out_sob_q   <= out_sob_d;
      out_last_q  <= out_last_d;
      out_bank_q  <= out_bank_d;
    end
  end

endmodule
